// File: rtl/hpu_lsu_iq_mp_if.sv
// Bundle of the LSU issue-queue insert, wakeup, control and issue signals.
// master drives the queue (decode/wakeup/LSQ side); slave is the queue itself.
interface hpu_lsu_iq_mp_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INS_W  = 2,
  parameter int unsigned ISS_W  = 2,
  parameter int unsigned WK_N   = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned PAY_W  = 64,
  parameter int unsigned CKPT_N = 4
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CK_W  = (CKPT_N > 1) ? $clog2(CKPT_N) : 1;

  logic                      flush_en_i;
  logic                      rcov_en_i;
  logic [CK_W-1:0]           rcov_idx_i;
  logic                      ins_vld_i;
  logic                      ins_rdy_o;
  logic [INS_W-1:0]          ins_avail_i;
  logic [INS_W*PAY_W-1:0]    ins_payload_i;
  logic [INS_W*TAG_W-1:0]    ins_rs1_tag_i;
  logic [INS_W*TAG_W-1:0]    ins_rs2_tag_i;
  logic [INS_W-1:0]          ins_rs1_rdy_i;
  logic [INS_W-1:0]          ins_rs2_rdy_i;
  logic [INS_W*CKPT_N-1:0]   ins_ckpt_i;
  logic [IDX_W:0]            left_size_o;
  logic [WK_N-1:0]           wk_en_i;
  logic [WK_N*TAG_W-1:0]     wk_tag_i;
  logic [ISS_W-1:0]          iss_vld_o;
  logic [ISS_W*PAY_W-1:0]    iss_payload_o;
  logic [ISS_W*CKPT_N-1:0]   iss_ckpt_o;
  logic [ISS_W-1:0]          iss_rdy_i;

  modport master (
    output flush_en_i, rcov_en_i, rcov_idx_i, ins_vld_i, ins_avail_i, ins_payload_i,
           ins_rs1_tag_i, ins_rs2_tag_i, ins_rs1_rdy_i, ins_rs2_rdy_i, ins_ckpt_i,
           wk_en_i, wk_tag_i, iss_rdy_i,
    input  ins_rdy_o, left_size_o, iss_vld_o, iss_payload_o, iss_ckpt_o
  );

  modport slave (
    input  flush_en_i, rcov_en_i, rcov_idx_i, ins_vld_i, ins_avail_i, ins_payload_i,
           ins_rs1_tag_i, ins_rs2_tag_i, ins_rs1_rdy_i, ins_rs2_rdy_i, ins_ckpt_i,
           wk_en_i, wk_tag_i, iss_rdy_i,
    output ins_rdy_o, left_size_o, iss_vld_o, iss_payload_o, iss_ckpt_o
  );
endinterface

// File: rtl/hpu_lsu_iq_mp.sv
// Multi-port in-order LSU issue queue: compacting insert, wakeup tracking, prefix issue, squash.
// Define HPU_LSU_IQ_WAKE_BYPASS_EN to let same-cycle wakeups qualify issue lanes.
module hpu_lsu_iq_mp #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INS_W  = 2,
  parameter int unsigned ISS_W  = 2,
  parameter int unsigned WK_N   = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned PAY_W  = 64,
  parameter int unsigned CKPT_N = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  hpu_lsu_iq_mp_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t              head_q, head_d, tail_q, tail_d;
  logic [PAY_W-1:0]  payload_q [DEPTH];
  logic [PAY_W-1:0]  payload_d [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_q [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_d [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_d [DEPTH];
  logic [CKPT_N-1:0] ckpt_q    [DEPTH];
  logic [CKPT_N-1:0] ckpt_d    [DEPTH];
  logic [DEPTH-1:0]  rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;

  function automatic logic wk_hit(input logic [WK_N-1:0]       en,
                                  input logic [WK_N*TAG_W-1:0] tags,
                                  input logic [TAG_W-1:0]      tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WK_N; p++) begin
      if (en[p] && (tags[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  ptr_t used, left;
  logic ins_fire;

  assign used             = tail_q - head_q;
  assign left             = ptr_t'(DEPTH) - used;
  assign bus.left_size_o  = left;
  assign bus.ins_rdy_o    = !bus.flush_en_i && !bus.rcov_en_i && (left >= ptr_t'(INS_W));
  assign ins_fire         = bus.ins_vld_i && bus.ins_rdy_o;

  // Compacted write slot for each insert lane.
  logic [IDX_W-1:0] ins_idx [INS_W];
  ptr_t             ins_cnt;

  always_comb begin
    ins_cnt = '0;
    for (int j = 0; j < INS_W; j++) begin
      ins_idx[j] = IDX_W'(tail_q + ins_cnt);
      if (bus.ins_avail_i[j]) ins_cnt = ins_cnt + PTR_ONE;
    end
  end

  logic [IDX_W-1:0] iss_idx [ISS_W];
  logic [ISS_W-1:0] src1_ok, src2_ok, lane_ok, iss_vld;
  logic             vld_run, fire_run;
  ptr_t             iss_cnt;

  always_comb begin
    for (int k = 0; k < ISS_W; k++) begin
      iss_idx[k] = IDX_W'(head_q + ptr_t'(k));
`ifdef HPU_LSU_IQ_WAKE_BYPASS_EN
      src1_ok[k] = rs1_rdy_q[iss_idx[k]] |
                   wk_hit(bus.wk_en_i, bus.wk_tag_i, rs1_tag_q[iss_idx[k]]);
      src2_ok[k] = rs2_rdy_q[iss_idx[k]] |
                   wk_hit(bus.wk_en_i, bus.wk_tag_i, rs2_tag_q[iss_idx[k]]);
`else
      src1_ok[k] = rs1_rdy_q[iss_idx[k]];
      src2_ok[k] = rs2_rdy_q[iss_idx[k]];
`endif
      lane_ok[k] = (ptr_t'(k) < used) && src1_ok[k] && src2_ok[k] &&
                   !(bus.rcov_en_i && ckpt_q[iss_idx[k]][bus.rcov_idx_i]);
    end
  end

  // Lanes form a prefix; the head advances only over the leading accepted lanes.
  always_comb begin
    iss_vld  = '0;
    iss_cnt  = '0;
    vld_run  = !bus.flush_en_i;
    fire_run = 1'b1;
    for (int k = 0; k < ISS_W; k++) begin
      vld_run    = vld_run && lane_ok[k];
      iss_vld[k] = vld_run;
      fire_run   = fire_run && vld_run && bus.iss_rdy_i[k];
      if (fire_run) iss_cnt = iss_cnt + PTR_ONE;
    end
  end

  always_comb begin
    bus.iss_vld_o     = iss_vld;
    bus.iss_payload_o = '0;
    bus.iss_ckpt_o    = '0;
    for (int k = 0; k < ISS_W; k++) begin
      bus.iss_payload_o[k*PAY_W +: PAY_W] = payload_q[iss_idx[k]];
      bus.iss_ckpt_o[k*CKPT_N +: CKPT_N]  = ckpt_q[iss_idx[k]];
    end
  end

  // Oldest resident entry depending on the recovered checkpoint becomes the new tail.
  logic rcov_hit;
  ptr_t rcov_ptr;

  always_comb begin
    rcov_hit = 1'b0;
    rcov_ptr = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rcov_hit && (ptr_t'(i) < used) &&
          ckpt_q[IDX_W'(head_q + ptr_t'(i))][bus.rcov_idx_i]) begin
        rcov_hit = 1'b1;
        rcov_ptr = head_q + ptr_t'(i);
      end
    end
  end

  always_comb begin
    head_d = head_q + iss_cnt;
    tail_d = tail_q;
    if (bus.flush_en_i) begin
      head_d = '0;
      tail_d = '0;
    end else if (bus.rcov_en_i) begin
      if (rcov_hit) tail_d = rcov_ptr;
    end else if (ins_fire) begin
      tail_d = tail_q + ins_cnt;
    end
  end

  always_comb begin
    payload_d = payload_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    ckpt_d    = ckpt_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (wk_hit(bus.wk_en_i, bus.wk_tag_i, rs1_tag_q[e])) rs1_rdy_d[e] = 1'b1;
      if (wk_hit(bus.wk_en_i, bus.wk_tag_i, rs2_tag_q[e])) rs2_rdy_d[e] = 1'b1;
    end
    if (ins_fire) begin
      for (int j = 0; j < INS_W; j++) begin
        if (bus.ins_avail_i[j]) begin
          payload_d[ins_idx[j]] = bus.ins_payload_i[j*PAY_W +: PAY_W];
          rs1_tag_d[ins_idx[j]] = bus.ins_rs1_tag_i[j*TAG_W +: TAG_W];
          rs2_tag_d[ins_idx[j]] = bus.ins_rs2_tag_i[j*TAG_W +: TAG_W];
          ckpt_d[ins_idx[j]]    = bus.ins_ckpt_i[j*CKPT_N +: CKPT_N];
          rs1_rdy_d[ins_idx[j]] = bus.ins_rs1_rdy_i[j] |
              wk_hit(bus.wk_en_i, bus.wk_tag_i, bus.ins_rs1_tag_i[j*TAG_W +: TAG_W]);
          rs2_rdy_d[ins_idx[j]] = bus.ins_rs2_rdy_i[j] |
              wk_hit(bus.wk_en_i, bus.wk_tag_i, bus.ins_rs2_tag_i[j*TAG_W +: TAG_W]);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        payload_q[e] <= '0;
        rs1_tag_q[e] <= '0;
        rs2_tag_q[e] <= '0;
        ckpt_q[e]    <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      payload_q <= payload_d;
      rs1_tag_q <= rs1_tag_d;
      rs2_tag_q <= rs2_tag_d;
      ckpt_q    <= ckpt_d;
    end
  end

endmodule

// File: tb/tb_hpu_lsu_iq_mp.sv
// Randomised scoreboard bench for hpu_lsu_iq_mp against a queue-based reference model.
// Honours HPU_LSU_IQ_WAKE_BYPASS_EN so the model matches the build under test.
module tb_hpu_lsu_iq_mp;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned INS_W  = 2;
  localparam int unsigned ISS_W  = 2;
  localparam int unsigned WK_N   = 4;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned PAY_W  = 64;
  localparam int unsigned CKPT_N = 4;
  localparam int unsigned CYCLES = 4000;
`ifdef HPU_LSU_IQ_WAKE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [PAY_W-1:0]  pay;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
    logic              r1;
    logic              r2;
    logic [CKPT_N-1:0] ck;
  } ent_t;

  typedef struct packed {
    logic [PAY_W-1:0]  pay;
    logic [CKPT_N-1:0] ck;
  } iss_t;

  typedef struct packed {
    logic [ISS_W-1:0] vld;
    logic             rdy;
    logic [4:0]       left;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  ent_t mq[$];
  iss_t exp_iss[$];
  st_t  exp_st[$];

  hpu_lsu_iq_mp_if #(
    .DEPTH(DEPTH), .INS_W(INS_W), .ISS_W(ISS_W), .WK_N(WK_N),
    .TAG_W(TAG_W), .PAY_W(PAY_W), .CKPT_N(CKPT_N)
  ) bus ();

  hpu_lsu_iq_mp #(
    .DEPTH(DEPTH), .INS_W(INS_W), .ISS_W(ISS_W), .WK_N(WK_N),
    .TAG_W(TAG_W), .PAY_W(PAY_W), .CKPT_N(CKPT_N)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PAY_W-1:0] act,
                       input logic [PAY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic woken(input logic [TAG_W-1:0] tag);
    logic h;
    h = 1'b0;
    for (int p = 0; p < WK_N; p++) begin
      if (bus.wk_en_i[p] && bus.wk_tag_i[p*TAG_W +: TAG_W] == tag) h = 1'b1;
    end
    return h;
  endfunction

  task automatic idle_inputs();
    bus.flush_en_i    = 1'b0;
    bus.rcov_en_i     = 1'b0;
    bus.rcov_idx_i    = '0;
    bus.ins_vld_i     = 1'b0;
    bus.ins_avail_i   = '0;
    bus.ins_payload_i = '0;
    bus.ins_rs1_tag_i = '0;
    bus.ins_rs2_tag_i = '0;
    bus.ins_rs1_rdy_i = '0;
    bus.ins_rs2_rdy_i = '0;
    bus.ins_ckpt_i    = '0;
    bus.wk_en_i       = '0;
    bus.wk_tag_i      = '0;
    bus.iss_rdy_i     = '0;
  endtask

  task automatic randomize_inputs();
    bus.flush_en_i = ($urandom_range(0, 39) == 0);
    bus.rcov_en_i  = ($urandom_range(0, 11) == 0);
    bus.rcov_idx_i = 2'($urandom_range(0, CKPT_N - 1));
    bus.ins_vld_i  = ($urandom_range(0, 9) < 7);
    bus.ins_avail_i = INS_W'($urandom);
    for (int j = 0; j < INS_W; j++) begin
      bus.ins_payload_i[j*PAY_W +: PAY_W] = {$urandom, $urandom};
      bus.ins_rs1_tag_i[j*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
      bus.ins_rs2_tag_i[j*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
      bus.ins_rs1_rdy_i[j] = $urandom_range(0, 1) == 1;
      bus.ins_rs2_rdy_i[j] = $urandom_range(0, 1) == 1;
      for (int b = 0; b < CKPT_N; b++) begin
        bus.ins_ckpt_i[j*CKPT_N + b] = ($urandom_range(0, 5) == 0);
      end
    end
    for (int p = 0; p < WK_N; p++) begin
      bus.wk_en_i[p] = ($urandom_range(0, 3) == 0);
      bus.wk_tag_i[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
    end
    bus.iss_rdy_i = ($urandom_range(0, 3) == 0) ? ISS_W'($urandom) : '1;
  endtask

  // Reference model: expected outputs for this cycle, then the model's next contents.
  task automatic model_step();
    st_t  st;
    int   used, cnt, cut;
    logic ok, run, r1, r2;
    ent_t e;
    iss_t is;
    used   = mq.size();
    st.left = 5'(DEPTH - used);
    st.rdy  = !bus.flush_en_i && !bus.rcov_en_i && (DEPTH - used >= INS_W);
    st.vld  = '0;
    ok      = !bus.flush_en_i;
    for (int k = 0; k < ISS_W; k++) begin
      if (ok && k < used) begin
        r1 = mq[k].r1 || (BYP && woken(mq[k].t1));
        r2 = mq[k].r2 || (BYP && woken(mq[k].t2));
        ok = r1 && r2 && !(bus.rcov_en_i && mq[k].ck[bus.rcov_idx_i]);
      end else begin
        ok = 1'b0;
      end
      st.vld[k] = ok;
    end
    cnt = 0;
    run = 1'b1;
    for (int k = 0; k < ISS_W; k++) begin
      run = run && st.vld[k] && bus.iss_rdy_i[k];
      if (run) begin
        is.pay = mq[k].pay;
        is.ck  = mq[k].ck;
        exp_iss.push_back(is);
        cnt++;
      end
    end
    exp_st.push_back(st);

    if (bus.flush_en_i) begin
      mq.delete();
    end else begin
      if (bus.rcov_en_i) begin
        cut = -1;
        for (int i = 0; i < used; i++) begin
          if (cut < 0 && mq[i].ck[bus.rcov_idx_i]) cut = i;
        end
        if (cut >= 0) while (mq.size() > cut) void'(mq.pop_back());
      end
      for (int k = 0; k < cnt; k++) void'(mq.pop_front());
      if (st.rdy && bus.ins_vld_i) begin
        for (int j = 0; j < INS_W; j++) begin
          if (bus.ins_avail_i[j]) begin
            e.pay = bus.ins_payload_i[j*PAY_W +: PAY_W];
            e.t1  = bus.ins_rs1_tag_i[j*TAG_W +: TAG_W];
            e.t2  = bus.ins_rs2_tag_i[j*TAG_W +: TAG_W];
            e.r1  = bus.ins_rs1_rdy_i[j];
            e.r2  = bus.ins_rs2_rdy_i[j];
            e.ck  = bus.ins_ckpt_i[j*CKPT_N +: CKPT_N];
            mq.push_back(e);
          end
        end
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (woken(mq[i].t1)) mq[i].r1 = 1'b1;
        if (woken(mq[i].t2)) mq[i].r2 = 1'b1;
      end
    end
  endtask

  // Monitor: compare the DUT against the scoreboard away from the active edge.
  always @(negedge clk) begin
    st_t  st;
    iss_t is;
    logic run;
    if (mon_en) begin
      if (exp_st.size() == 0) begin
        check("status_queue_empty", 1, 0);
      end else begin
        st = exp_st.pop_front();
        check("iss_vld", PAY_W'(bus.iss_vld_o), PAY_W'(st.vld));
        check("ins_rdy", PAY_W'(bus.ins_rdy_o), PAY_W'(st.rdy));
        check("left_size", PAY_W'(bus.left_size_o), PAY_W'(st.left));
      end
      run = 1'b1;
      for (int k = 0; k < ISS_W; k++) begin
        run = run && bus.iss_vld_o[k] && bus.iss_rdy_i[k];
        if (run) begin
          if (exp_iss.size() == 0) begin
            check("unexpected_issue", 1, 0);
          end else begin
            is = exp_iss.pop_front();
            check("iss_payload", bus.iss_payload_o[k*PAY_W +: PAY_W], is.pay);
            check("iss_ckpt", PAY_W'(bus.iss_ckpt_o[k*CKPT_N +: CKPT_N]), PAY_W'(is.ck));
          end
        end
      end
    end
  end

  initial begin
    idle_inputs();
    #12;
    check("reset_iss_vld", PAY_W'(bus.iss_vld_o), '0);
    check("reset_left_size", PAY_W'(bus.left_size_o), PAY_W'(DEPTH));
    check("reset_ins_rdy", PAY_W'(bus.ins_rdy_o), PAY_W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < CYCLES; c++) begin
      @(posedge clk);
      #1;
      if (c < 2) idle_inputs();
      else randomize_inputs();
      mon_en = 1'b1;
      model_step();
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("issue_queue_drained", PAY_W'(exp_iss.size()), '0);
    check("status_queue_drained", PAY_W'(exp_st.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
